// File: rtl/pb_event_reader.sv
// Push-button reader: 2-flop sync, per-bit debounce FSM, press-event mask on a valid/ready port.
// Latency: pb_n step -> pb_level/evt_data after DEBOUNCE_CYCLES+2 edges. Backpressure: events merge
// into the pending mask while evt_ready is low; evt_overflow flags a merge. Optional: PB_EVT_RELEASE_EN.
module pb_event_reader #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pb_n,
    output logic [WIDTH-1:0] pb_level,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    input  logic             evt_ready,
`ifdef PB_EVT_RELEASE_EN
    output logic [WIDTH-1:0] evt_release,
`endif
    output logic             evt_overflow,
    input  logic             ovf_clear
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_t;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] s;

    db_state_t        state_q [WIDTH];
    db_state_t        state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
    logic             accept;
`ifdef PB_EVT_RELEASE_EN
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rel_q, rel_d;
`endif

    // Synchronizer flops idle at 1 so the debouncer sees "released" out of reset.
    always_comb begin
        sync1_d = pb_n;
        sync2_d = sync1_q;
    end

    assign s = ~sync2_q;

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (s[i] != level_q[i]) begin
                        state_d[i] = ST_COUNTING;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                ST_COUNTING: begin
                    if (s[i] == level_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        level_d[i] = ~level_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Rise is taken from the next level so the event lands on the same edge as pb_level.
    always_comb begin
        rise    = level_d & ~level_q;
        accept  = valid_q & evt_ready;
        data_d  = (accept ? '0 : data_q) | rise;
        ovf_set = (|(rise & data_q)) & ~accept;
`ifdef PB_EVT_RELEASE_EN
        fall    = ~level_d & level_q;
        rel_d   = (accept ? '0 : rel_q) | fall;
        ovf_set = ovf_set | ((|(fall & rel_q)) & ~accept);
        valid_d = |(data_d | rel_d);
`else
        valid_d = |data_d;
`endif
        ovf_d   = ovf_set | (ovf_q & ~ovf_clear);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef PB_EVT_RELEASE_EN
            rel_q   <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q <= level_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
`ifdef PB_EVT_RELEASE_EN
            rel_q   <= rel_d;
`endif
        end
    end

    assign pb_level     = level_q;
    assign evt_data     = data_q;
    assign evt_valid    = valid_q;
    assign evt_overflow = ovf_q;
`ifdef PB_EVT_RELEASE_EN
    assign evt_release  = rel_q;
`endif

endmodule
